pipe_ctrl_unit: RTL and testbench

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

---
 rtl/pipe_ctrl_pkg.sv | 99 +++++++++
 rtl/ctrl_decoder.sv | 84 ++++++++
 rtl/pipe_ctrl_unit.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-bundle types for the pipeline control unit.
package pipe_ctrl_pkg;

    // Supported major opcodes
    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    // ALU operation codes
    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSll  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSra  = 4'b0111;
    localparam logic [3:0] AluSlt  = 4'b1000;
    localparam logic [3:0] AluSltu = 4'b1001;

    // Write-back source select
    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbPc4 = 2'd2;

    // Full control bundle captured into ID/EX
    typedef struct packed {
        logic       valid;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       branch;
        logic       jump;
        logic [2:0] fun3;
    } ctrl_t;

    // Subset of the bundle still needed once the instruction leaves EX
    typedef struct packed {
        logic       valid;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic [1:0] wb_sel;
    } mem_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] wb_sel;
    } wb_ctrl_t;

    localparam ctrl_t CtrlBubble = '0;

    // ALU op for R-type and I-ALU; fun7_5 only means SUB for R-type
    function automatic logic [3:0] alu_from_fun3(input logic [2:0] fun3,
                                                 input logic       fun7_5,
                                                 input logic       is_r);
        logic [3:0] op;
        op = AluAdd;
        case (fun3)
            3'b000:  op = (is_r && fun7_5) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = fun7_5 ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    // Branch outcome from fun3 and the EX-stage ALU flags
    function automatic logic branch_taken(input logic [2:0] fun3,
                                          input logic       zero,
                                          input logic       less,
                                          input logic       less_u);
        logic taken;
        taken = 1'b0;
        case (fun3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = less;
            3'b101:  taken = !less;
            3'b110:  taken = less_u;
            3'b111:  taken = !less_u;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational ID-stage decoder: builds the control bundle and operand-use flags.
module ctrl_decoder
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RF_AW = 5
) (
    input  logic             valid,
    input  logic [6:0]       opcode,
    input  logic [2:0]       fun3,
    input  logic             fun7_5,
    input  logic [RF_AW-1:0] rd,
    output ctrl_t            ctrl,
    output logic             illegal,
    output logic             use_rs1,
    output logic             use_rs2
);

    ctrl_t dec;
    logic  known;
    logic  bad_fun3;

    // Opcode decode; unsupported or invalid instructions collapse to a bubble
    always_comb begin
        dec       = CtrlBubble;
        known     = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        dec.valid = 1'b1;
        dec.fun3  = fun3;
        case (opcode)
            OpcR: begin
                dec.alu_ctrl  = alu_from_fun3(fun3, fun7_5, 1'b1);
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OpcImm: begin
                dec.alu_ctrl  = alu_from_fun3(fun3, fun7_5, 1'b0);
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
            end
            OpcLoad: begin
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = WbMem;
                use_rs1       = 1'b1;
            end
            OpcStore: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OpcBranch: begin
                dec.alu_ctrl = AluSub;
                dec.branch   = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OpcJal: begin
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = WbPc4;
            end
            OpcJalr: begin
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = WbPc4;
                use_rs1       = 1'b1;
            end
            default: known = 1'b0;
        endcase
        bad_fun3      = (opcode == OpcBranch) && ((fun3 == 3'b010) || (fun3 == 3'b011));
        illegal       = valid && (!known || bad_fun3);
        // x0 is never written
        dec.reg_write = dec.reg_write && (rd != '0);
        ctrl          = (valid && !illegal) ? dec : CtrlBubble;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: decode, load-use / redirect hazards, stage registers, event counters.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RF_AW = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [2:0]       id_fun3,
    input  logic             id_fun7_5,
    input  logic [RF_AW-1:0] id_rs1,
    input  logic [RF_AW-1:0] id_rs2,
    input  logic [RF_AW-1:0] id_rd,
    input  logic             ex_zero,
    input  logic             ex_less,
    input  logic             ex_less_u,
    output logic             ex_valid,
    output logic [3:0]       ex_alu_ctrl,
    output logic             ex_alu_src,
    output logic             mem_valid,
    output logic             mem_write,
    output logic             mem_read,
    output logic             wb_valid,
    output logic             wb_reg_write,
    output logic [1:0]       wb_sel,
    output logic [RF_AW-1:0] wb_rd,
    output logic             pc_sel,
    output logic             flush,
    output logic             stall,
    output logic             id_illegal,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_t            id_ctrl;
    logic             id_use_rs1;
    logic             id_use_rs2;
    ctrl_t            ex_d, ex_q;
    logic [RF_AW-1:0] ex_rd_d, ex_rd_q;
    mem_ctrl_t        mem_q;
    logic [RF_AW-1:0] mem_rd_q;
    wb_ctrl_t         wb_q;
    logic [RF_AW-1:0] wb_rd_q;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    ctrl_decoder #(
        .RF_AW(RF_AW)
    ) u_decoder (
        .valid  (id_valid),
        .opcode (id_opcode),
        .fun3   (id_fun3),
        .fun7_5 (id_fun7_5),
        .rd     (id_rd),
        .ctrl   (id_ctrl),
        .illegal(id_illegal),
        .use_rs1(id_use_rs1),
        .use_rs2(id_use_rs2)
    );

    // Redirect from EX and load-use detection; a redirect masks the stall
    always_comb begin
        pc_sel   = ex_q.valid &&
                   (ex_q.jump ||
                    (ex_q.branch && branch_taken(ex_q.fun3, ex_zero, ex_less, ex_less_u)));
        flush    = pc_sel;
        load_use = ex_q.valid && ex_q.mem_read && (ex_rd_q != '0) && id_valid &&
                   ((id_use_rs1 && (id_rs1 == ex_rd_q)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd_q)));
        stall    = load_use && !pc_sel;
    end

    // Next ID/EX contents: bubble on redirect, load-use or no usable instruction
    always_comb begin
        ex_d    = id_ctrl;
        ex_rd_d = id_rd;
        if (!id_ctrl.valid || pc_sel || load_use) begin
            ex_d    = CtrlBubble;
            ex_rd_d = '0;
        end
    end

    // Stage registers; EX/MEM and MEM/WB always advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= CtrlBubble;
            ex_rd_q  <= '0;
            mem_q    <= '0;
            mem_rd_q <= '0;
            wb_q     <= '0;
            wb_rd_q  <= '0;
        end else begin
            ex_q     <= ex_d;
            ex_rd_q  <= ex_rd_d;
            mem_q    <= '{valid:     ex_q.valid,
                          mem_write: ex_q.mem_write,
                          mem_read:  ex_q.mem_read,
                          reg_write: ex_q.reg_write,
                          wb_sel:    ex_q.wb_sel};
            mem_rd_q <= ex_rd_q;
            wb_q     <= '{valid:     mem_q.valid,
                          reg_write: mem_q.reg_write,
                          wb_sel:    mem_q.wb_sel};
            wb_rd_q  <= mem_rd_q;
        end
    end

    // Saturating stall / flush event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_alu_ctrl  = ex_q.alu_ctrl;
    assign ex_alu_src   = ex_q.alu_src;
    assign mem_valid    = mem_q.valid;
    assign mem_write    = mem_q.mem_write;
    assign mem_read     = mem_q.mem_read;
    assign wb_valid     = wb_q.valid;
    assign wb_reg_write = wb_q.reg_write;
    assign wb_sel       = wb_q.wb_sel;
    assign wb_rd        = wb_rd_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: cycle-history model plus directed literal checks.
module tb_pipe_ctrl_unit;

    localparam int RF_AW  = 5;
    localparam int CNT_W  = 4;
    localparam int CntMax = 15;
    localparam int HistSz = 4096;

    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSt  = 7'b0100011;
    localparam logic [6:0] OpBr  = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;
    localparam logic [6:0] OpJlr = 7'b1100111;
    localparam logic [6:0] OpLui = 7'b0110111;

    logic             clk, rst_n, id_valid, id_fun7_5, ex_zero, ex_less, ex_less_u;
    logic [6:0]       id_opcode;
    logic [2:0]       id_fun3;
    logic [RF_AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic             ex_valid, ex_alu_src, mem_valid, mem_write, mem_read;
    logic             wb_valid, wb_reg_write, pc_sel, flush, stall, id_illegal;
    logic [3:0]       ex_alu_ctrl;
    logic [1:0]       wb_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_ctrl_unit #(
        .RF_AW(RF_AW),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_fun3     (id_fun3),
        .id_fun7_5   (id_fun7_5),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .ex_zero     (ex_zero),
        .ex_less     (ex_less),
        .ex_less_u   (ex_less_u),
        .ex_valid    (ex_valid),
        .ex_alu_ctrl (ex_alu_ctrl),
        .ex_alu_src  (ex_alu_src),
        .mem_valid   (mem_valid),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .wb_valid    (wb_valid),
        .wb_reg_write(wb_reg_write),
        .wb_sel      (wb_sel),
        .wb_rd       (wb_rd),
        .pc_sel      (pc_sel),
        .flush       (flush),
        .stall       (stall),
        .id_illegal  (id_illegal),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One instruction as it entered EX at a given cycle (v=0 means a bubble)
    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } inst_t;

    function automatic bit known(input logic [6:0] op);
        return op inside {OpR, OpI, OpLd, OpSt, OpBr, OpJal, OpJlr};
    endfunction

    function automatic bit illegal_of(input inst_t i);
        return i.v && (!known(i.op) || (i.op == OpBr && (i.f3 == 3'd2 || i.f3 == 3'd3)));
    endfunction

    function automatic logic [3:0] alu_exp(input inst_t i);
        logic [3:0] r;
        r = 4'd0;
        if (i.op == OpR || i.op == OpI) begin
            case (i.f3)
                3'd0: r = (i.op == OpR && i.f7) ? 4'd1 : 4'd0;
                3'd1: r = 4'd5;
                3'd2: r = 4'd8;
                3'd3: r = 4'd9;
                3'd4: r = 4'd4;
                3'd5: r = i.f7 ? 4'd7 : 4'd6;
                3'd6: r = 4'd3;
                default: r = 4'd2;
            endcase
        end else if (i.op == OpBr) begin
            r = 4'd1;
        end
        return r;
    endfunction

    function automatic bit src_exp(input logic [6:0] op);
        return op inside {OpI, OpLd, OpSt, OpJal, OpJlr};
    endfunction

    function automatic bit writes(input logic [6:0] op);
        return op inside {OpR, OpI, OpLd, OpJal, OpJlr};
    endfunction

    function automatic logic [1:0] wsel_exp(input logic [6:0] op);
        if (op == OpLd) return 2'd1;
        if (op == OpJal || op == OpJlr) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit uses1(input logic [6:0] op);
        return op inside {OpR, OpI, OpLd, OpSt, OpBr, OpJlr};
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op inside {OpR, OpSt, OpBr};
    endfunction

    function automatic bit taken(input logic [2:0] f3, input bit z, input bit l, input bit lu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    inst_t hist [HistSz];
    int    mc = 3;
    int    m_sc = 0;
    int    m_fc = 0;
    bit    m_stall_edge = 1'b0;

    initial begin
        for (int i = 0; i < HistSz; i++) hist[i] = '0;
    end

    // Compare every cycle against the history model, then advance it for the coming edge
    always @(negedge clk) begin : cmp
        inst_t e_ex, e_mem, e_wb, cur;
        bit    exp_pc, exp_haz, exp_stall;
        if (!rst_n) begin
            hist[(mc - 1) % HistSz] = '0;
            hist[(mc - 2) % HistSz] = '0;
            hist[(mc - 3) % HistSz] = '0;
            m_sc         = 0;
            m_fc         = 0;
            m_stall_edge = 1'b0;
        end else begin
            e_ex  = hist[(mc - 1) % HistSz];
            e_mem = hist[(mc - 2) % HistSz];
            e_wb  = hist[(mc - 3) % HistSz];
            cur.v   = id_valid;
            cur.op  = id_opcode;
            cur.f3  = id_fun3;
            cur.f7  = id_fun7_5;
            cur.rd  = id_rd;
            cur.rs1 = id_rs1;
            cur.rs2 = id_rs2;
            exp_pc  = e_ex.v && (e_ex.op == OpJal || e_ex.op == OpJlr ||
                      (e_ex.op == OpBr && taken(e_ex.f3, ex_zero, ex_less, ex_less_u)));
            exp_haz = e_ex.v && e_ex.op == OpLd && e_ex.rd != 0 && id_valid &&
                      ((uses1(id_opcode) && id_rs1 == e_ex.rd) ||
                       (uses2(id_opcode) && id_rs2 == e_ex.rd));
            exp_stall = exp_haz && !exp_pc;

            check("ex_valid", 32'(ex_valid), 32'(e_ex.v));
            check("ex_alu_ctrl", 32'(ex_alu_ctrl), e_ex.v ? 32'(alu_exp(e_ex)) : 0);
            check("ex_alu_src", 32'(ex_alu_src), 32'(e_ex.v && src_exp(e_ex.op)));
            check("mem_valid", 32'(mem_valid), 32'(e_mem.v));
            check("mem_write", 32'(mem_write), 32'(e_mem.v && e_mem.op == OpSt));
            check("mem_read", 32'(mem_read), 32'(e_mem.v && e_mem.op == OpLd));
            check("wb_valid", 32'(wb_valid), 32'(e_wb.v));
            check("wb_reg_write", 32'(wb_reg_write),
                  32'(e_wb.v && writes(e_wb.op) && e_wb.rd != 0));
            check("wb_sel", 32'(wb_sel), e_wb.v ? 32'(wsel_exp(e_wb.op)) : 0);
            check("wb_rd", 32'(wb_rd), 32'(e_wb.rd));
            check("pc_sel", 32'(pc_sel), 32'(exp_pc));
            check("flush", 32'(flush), 32'(exp_pc));
            check("stall", 32'(stall), 32'(exp_stall));
            check("id_illegal", 32'(id_illegal), 32'(illegal_of(cur)));
            check("stall_cnt", 32'(stall_cnt), 32'(m_sc));
            check("flush_cnt", 32'(flush_cnt), 32'(m_fc));

            if (!cur.v || illegal_of(cur) || exp_pc || exp_haz) cur = '0;
            hist[mc % HistSz] = cur;
            mc++;
            if (exp_stall && m_sc < CntMax) m_sc++;
            if (exp_pc && m_fc < CntMax) m_fc++;
            m_stall_edge = exp_stall;
        end
    end

    task automatic drv(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid  = 1'b1;
        id_opcode = op;
        id_fun3   = f3;
        id_fun7_5 = f7;
        id_rd     = rd;
        id_rs1    = rs1;
        id_rs2    = rs2;
    endtask

    task automatic flags(input logic z, input logic l, input logic lu);
        ex_zero   = z;
        ex_less   = l;
        ex_less_u = lu;
    endtask

    task automatic idle();
        drv(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        id_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and hold it in ID for as long as it is stalled
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic z, input logic l, input logic lu);
        int n;
        n = 0;
        drv(op, f3, f7, rd, rs1, rs2);
        flags(z, l, lu);
        do begin
            tick();
            n++;
        end while (m_stall_edge && n < 4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        flags(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_pc_sel", 32'(pc_sel), 0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        rst_n = 1'b1;
        tick();

        // ADD rd=3 through the pipe
        drv(OpR, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2);
        tick();
        idle();
        #1;
        check("add_ex_valid", 32'(ex_valid), 1);
        check("add_ex_alu", 32'(ex_alu_ctrl), 0);
        tick();
        tick();
        #1;
        check("add_wb_valid", 32'(wb_valid), 1);
        check("add_wb_reg_write", 32'(wb_reg_write), 1);
        check("add_wb_rd", 32'(wb_rd), 3);
        check("add_wb_sel", 32'(wb_sel), 0);

        // SUB then SRAI
        drv(OpR, 3'd0, 1'b1, 5'd4, 5'd1, 5'd2);
        tick();
        drv(OpI, 3'd5, 1'b1, 5'd5, 5'd1, 5'd0);
        #1;
        check("sub_ex_alu", 32'(ex_alu_ctrl), 1);
        tick();
        idle();
        #1;
        check("srai_ex_alu", 32'(ex_alu_ctrl), 7);
        tick();

        // Load-use with rd=5
        drv(OpLd, 3'd2, 1'b0, 5'd5, 5'd1, 5'd0);
        tick();
        drv(OpR, 3'd0, 1'b0, 5'd6, 5'd1, 5'd5);
        #1;
        check("lu_stall", 32'(stall), 1);
        tick();
        #1;
        check("lu_bubble", 32'(ex_valid), 0);
        check("lu_stall_drop", 32'(stall), 0);
        check("lu_stall_cnt", 32'(stall_cnt), 1);
        tick();
        idle();
        #1;
        check("lu_add_enters", 32'(ex_valid), 1);
        tick();

        // Same with rd=0: no hazard
        drv(OpLd, 3'd2, 1'b0, 5'd0, 5'd1, 5'd0);
        tick();
        drv(OpR, 3'd0, 1'b0, 5'd6, 5'd1, 5'd0);
        #1;
        check("lu_x0_stall", 32'(stall), 0);
        tick();
        idle();
        #1;
        check("lu_x0_ex_valid", 32'(ex_valid), 1);
        check("lu_x0_stall_cnt", 32'(stall_cnt), 1);
        tick();

        // BNE taken
        drv(OpBr, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2);
        tick();
        drv(OpR, 3'd0, 1'b0, 5'd7, 5'd8, 5'd9);
        flags(1'b0, 1'b0, 1'b0);
        #1;
        check("bne_pc_sel", 32'(pc_sel), 1);
        check("bne_flush", 32'(flush), 1);
        tick();
        idle();
        #1;
        check("bne_bubble", 32'(ex_valid), 0);
        check("bne_flush_cnt", 32'(flush_cnt), 1);
        tick();

        // BNE not taken
        drv(OpBr, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2);
        tick();
        drv(OpR, 3'd0, 1'b0, 5'd7, 5'd8, 5'd9);
        flags(1'b1, 1'b0, 1'b0);
        #1;
        check("bne_nt_flush", 32'(flush), 0);
        tick();
        idle();
        flags(1'b0, 1'b0, 1'b0);
        #1;
        check("bne_nt_ex_valid", 32'(ex_valid), 1);
        check("bne_nt_flush_cnt", 32'(flush_cnt), 1);
        tick();

        // BLTU taken while its rd field matches an ID source
        drv(OpBr, 3'd6, 1'b0, 5'd5, 5'd1, 5'd2);
        tick();
        drv(OpR, 3'd0, 1'b0, 5'd6, 5'd1, 5'd5);
        flags(1'b0, 1'b0, 1'b1);
        #1;
        check("bltu_flush", 32'(flush), 1);
        check("bltu_stall", 32'(stall), 0);
        tick();
        idle();
        flags(1'b0, 1'b0, 1'b0);
        #1;
        check("bltu_bubble", 32'(ex_valid), 0);
        tick();

        // Illegal opcodes and branch fun3
        drv(OpLui, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0);
        #1;
        check("lui_illegal", 32'(id_illegal), 1);
        tick();
        idle();
        #1;
        check("lui_bubble", 32'(ex_valid), 0);
        check("idle_not_illegal", 32'(id_illegal), 0);
        tick();
        tick();
        #1;
        check("lui_wb_valid", 32'(wb_valid), 0);
        check("lui_wb_write", 32'(wb_reg_write), 0);
        drv(OpBr, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2);
        #1;
        check("br010_illegal", 32'(id_illegal), 1);
        tick();

        // Mixed sweep checked by the model
        issue(OpI,  3'd0, 1'b1, 5'd1,  5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpI,  3'd1, 1'b0, 5'd2,  5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpI,  3'd2, 1'b0, 5'd3,  5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpI,  3'd3, 1'b0, 5'd4,  5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpI,  3'd4, 1'b0, 5'd5,  5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpI,  3'd5, 1'b0, 5'd6,  5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpI,  3'd6, 1'b0, 5'd7,  5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpI,  3'd7, 1'b0, 5'd8,  5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd1, 1'b0, 5'd9,  5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd2, 1'b0, 5'd10, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd3, 1'b0, 5'd11, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd4, 1'b0, 5'd12, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd5, 1'b0, 5'd13, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd6, 1'b0, 5'd14, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd7, 1'b0, 5'd0,  5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        issue(OpLd, 3'd2, 1'b0, 5'd7,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpSt, 3'd2, 1'b0, 5'd0,  5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
        issue(OpLd, 3'd2, 1'b0, 5'd8,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpJal, 3'd0, 1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd0, 1'b0, 5'd3,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        issue(OpLd, 3'd2, 1'b0, 5'd9,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpI,  3'd0, 1'b0, 5'd2,  5'd1, 5'd9, 1'b0, 1'b0, 1'b0);
        issue(OpBr, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd0, 1'b0, 5'd3,  5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        issue(OpBr, 3'd4, 1'b0, 5'd0,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd0, 1'b0, 5'd3,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        issue(OpBr, 3'd5, 1'b0, 5'd0,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd0, 1'b0, 5'd3,  5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
        issue(OpBr, 3'd7, 1'b0, 5'd0,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        issue(OpR,  3'd0, 1'b0, 5'd3,  5'd1, 5'd2, 1'b0, 1'b0, 1'b1);
        issue(OpJlr, 3'd0, 1'b0, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(OpSt, 3'd2, 1'b0, 5'd0,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        issue(OpLd, 3'd2, 1'b0, 5'd0,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();
        flags(1'b0, 1'b0, 1'b0);
        repeat (4) tick();

        // Saturate the stall counter
        for (int i = 0; i < 20; i++) begin
            issue(OpLd, 3'd2, 1'b0, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
            issue(OpR,  3'd0, 1'b0, 5'd6, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        tick();
        #1;
        check("stall_cnt_sat", 32'(stall_cnt), CntMax);

        // Saturate the flush counter with back-to-back JALs
        drv(OpJal, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0);
        repeat (40) tick();
        idle();
        tick();
        tick();
        #1;
        check("flush_cnt_sat", 32'(flush_cnt), CntMax);

        // Reset with a full pipeline and a redirect pending in EX
        drv(OpR, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2);
        tick();
        drv(OpR, 3'd0, 1'b0, 5'd4, 5'd1, 5'd2);
        tick();
        drv(OpJal, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0);
        tick();
        idle();
        #1;
        check("pre_rst_pc_sel", 32'(pc_sel), 1);
        check("pre_rst_wb_write", 32'(wb_reg_write), 1);
        check("pre_rst_wb_rd", 32'(wb_rd), 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ex_valid", 32'(ex_valid), 0);
        check("mid_rst_mem_valid", 32'(mem_valid), 0);
        check("mid_rst_wb_valid", 32'(wb_valid), 0);
        check("mid_rst_wb_write", 32'(wb_reg_write), 0);
        check("mid_rst_wb_rd", 32'(wb_rd), 0);
        check("mid_rst_pc_sel", 32'(pc_sel), 0);
        check("mid_rst_flush_cnt", 32'(flush_cnt), 0);
        check("mid_rst_stall_cnt", 32'(stall_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        check("post_rst_wb_write", 32'(wb_reg_write), 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
